// File: rtl/microwave_ctrl.sv
// microwave_ctrl -- cooking sequencer for a microwave oven.
//
// Watches the start/stop buttons and the door switch, drives the
// magnetron, lamp and buzzer, and steps an external chain of
// down-counting timer digits through count_en / clear_n.
//
// Ports:
//   clk          in   rising-edge clock for all state
//   clr          in   synchronous active-high reset
//   start        in   start button level (synchronous to clk)
//   stop         in   stop/cancel button level (synchronous to clk)
//   door_closed  in   1 = door closed
//   zero_all     in   1 = all timer digits read zero
//   count_en     out  one-cycle decrement strobe to the LS timer digit
//   clear_n      out  active-low one-cycle clear of all timer digits
//   mag_on       out  magnetron drive
//   lamp         out  cavity lamp
//   beep         out  buzzer drive
//   state        out  state code: IDLE=0, COOK=1, PAUSE=2, DONE=3
//
// Button handshake: a press is the rising edge of the button level
// (level high now, low in the previous cycle); holding a button down
// produces exactly one press.

module microwave_ctrl #(
    parameter int TICK_DIV  = 100,
    parameter int BEEP_SECS = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       zero_all,
    output logic       count_en,
    output logic       clear_n,
    output logic       mag_on,
    output logic       lamp,
    output logic       beep,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BEEP_SECS + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q,      state_d;
    logic [PW-1:0] presc_q,      presc_d;
    logic [BW-1:0] beep_cnt_q,   beep_cnt_d;
    logic          start_prev_q, start_prev_d;
    logic          stop_prev_q,  stop_prev_d;
    logic          clear_n_q,    clear_n_d;

    logic          start_press;
    logic          stop_press;
    logic          wrap;
    logic [PW-1:0] presc_inc;

    assign start_press = start & ~start_prev_q;
    assign stop_press  = stop  & ~stop_prev_q;
    assign wrap        = (presc_q == PRESC_MAX);
    assign presc_inc   = wrap ? '0 : presc_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        beep_cnt_d   = beep_cnt_q;
        clear_n_d    = 1'b1;
        start_prev_d = start;
        stop_prev_d  = stop;
        count_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (stop_press) begin
                    clear_n_d = 1'b0;
                end else if (start_press && door_closed && !zero_all) begin
                    state_d = ST_COOK;
                    presc_d = '0;
                end
            end

            ST_COOK: begin
                // The prescaler runs in every COOK cycle, including the one
                // that leaves for PAUSE; only entry to DONE restarts it.
                presc_d = presc_inc;
                if (!door_closed) begin
                    state_d = ST_PAUSE;
                end else if (stop_press) begin
                    state_d = ST_PAUSE;
                end else if (zero_all) begin
                    state_d    = ST_DONE;
                    presc_d    = '0;
                    beep_cnt_d = '0;
                end else begin
                    // Reaching this branch already implies door closed,
                    // no stop press and digits non-zero.
                    count_en = wrap;
                end
            end

            ST_PAUSE: begin
                // Stop wins over a simultaneous start; prescaler is held so
                // the partial second is resumed on return to COOK.
                if (stop_press) begin
                    state_d   = ST_IDLE;
                    clear_n_d = 1'b0;
                end else if (start_press && door_closed) begin
                    state_d = ST_COOK;
                end
            end

            ST_DONE: begin
                presc_d = presc_inc;
                if (stop_press || !door_closed) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    if (beep_cnt_q == BEEP_LAST) begin
                        state_d    = ST_IDLE;
                        beep_cnt_d = '0;
                    end else begin
                        beep_cnt_d = beep_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            beep_cnt_q   <= '0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            clear_n_q    <= 1'b0;  // reset also wipes the timer digits
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            beep_cnt_q   <= beep_cnt_d;
            start_prev_q <= start_prev_d;
            stop_prev_q  <= stop_prev_d;
            clear_n_q    <= clear_n_d;
        end
    end

    assign clear_n = clear_n_q;
    assign mag_on  = (state_q == ST_COOK);
    assign lamp    = (state_q == ST_COOK) | ~door_closed;
    assign beep    = (state_q == ST_DONE);
    assign state   = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed testbench for microwave_ctrl with TICK_DIV=4, BEEP_SECS=3.
// Inputs change 1 time unit after the rising edge; outputs are checked
// on the falling edge.

module tb_microwave_ctrl;

    logic       clk;
    logic       clr;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       zero_all;
    logic       count_en;
    logic       clear_n;
    logic       mag_on;
    logic       lamp;
    logic       beep;
    logic [1:0] state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    microwave_ctrl #(
        .TICK_DIV  (4),
        .BEEP_SECS (3)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .zero_all    (zero_all),
        .count_en    (count_en),
        .clear_n     (clear_n),
        .mag_on      (mag_on),
        .lamp        (lamp),
        .beep        (beep),
        .state       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver helpers
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        assert (got === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin : stim
        int n;
        int en_seen;

        clr = 1'b1; start = 1'b0; stop = 1'b0; door_closed = 1'b1; zero_all = 1'b0;

        // reset
        nxt();
        mid();
        check("rst_state", 8'(state), 8'd0);
        check("rst_clear_n", 8'(clear_n), 8'd0);
        check("rst_mag", 8'(mag_on), 8'd0);
        clr = 1'b0;
        nxt();
        mid();
        check("post_rst_state", 8'(state), 8'd0);
        check("post_rst_clear_n", 8'(clear_n), 8'd1);
        check("post_rst_mag", 8'(mag_on), 8'd0);
        check("post_rst_beep", 8'(beep), 8'd0);
        check("post_rst_count_en", 8'(count_en), 8'd0);
        check("post_rst_lamp", 8'(lamp), 8'd0);

        // start press -> COOK, count_en every 4th cycle
        nxt();
        start = 1'b1;
        mid();
        check("idle_start_no_en", 8'(count_en), 8'd0);
        nxt();
        start = 1'b0;
        mid();
        check("cook_state", 8'(state), 8'd1);
        check("cook_mag", 8'(mag_on), 8'd1);
        check("cook_lamp", 8'(lamp), 8'd1);
        for (int i = 0; i < 8; i++) begin
            if (i != 0) mid();
            check($sformatf("cook_en_%0d", i), 8'(count_en), (i % 4 == 3) ? 8'd1 : 8'd0);
            nxt();
        end
        // prescaler now 0; one more cycle -> 1
        nxt();

        // door open for one cycle -> PAUSE
        door_closed = 1'b0;
        mid();
        check("door_open_no_en", 8'(count_en), 8'd0);
        nxt();
        door_closed = 1'b1;
        mid();
        check("pause_state", 8'(state), 8'd2);
        check("pause_mag", 8'(mag_on), 8'd0);
        check("pause_en", 8'(count_en), 8'd0);
        nxt();
        start = 1'b1;
        mid();
        check("pause_held", 8'(state), 8'd2);
        nxt();
        start = 1'b0;
        // prescaler resumes at 2: pulse in the second COOK cycle
        mid();
        check("resume_state", 8'(state), 8'd1);
        check("resume_en0", 8'(count_en), 8'd0);
        nxt();
        mid();
        check("resume_en1", 8'(count_en), 8'd1);
        nxt();

        // zero_all -> DONE, 12 beep cycles, then IDLE
        zero_all = 1'b1;
        mid();
        check("zero_no_en", 8'(count_en), 8'd0);
        nxt();
        n = 0;
        en_seen = 0;
        mid();
        check("done_state", 8'(state), 8'd3);
        while (beep === 1'b1 && n < 20) begin
            if (count_en !== 1'b0) en_seen++;
            n++;
            nxt();
            mid();
        end
        check("beep_cycles", 8'(n), 8'd12);
        check("done_no_en", 8'(en_seen), 8'd0);
        check("done_exit_state", 8'(state), 8'd0);
        check("done_exit_beep", 8'(beep), 8'd0);
        nxt();

        // start with zero_all=1 is ignored
        start = 1'b1;
        nxt();
        start = 1'b0;
        mid();
        check("zero_start_ignored", 8'(state), 8'd0);
        nxt();

        // COOK, stop press at prescaler 3 suppresses count_en
        zero_all = 1'b0;
        start = 1'b1;
        nxt();
        start = 1'b0;
        nxt();
        nxt();
        nxt();
        stop = 1'b1;
        mid();
        check("stop_suppress_en", 8'(count_en), 8'd0);
        nxt();
        stop = 1'b0;
        mid();
        check("stop_to_pause", 8'(state), 8'd2);
        check("stop_cook_clear_n", 8'(clear_n), 8'd1);
        nxt();

        // PAUSE: simultaneous start and stop -> IDLE with one clear
        start = 1'b1;
        stop = 1'b1;
        nxt();
        start = 1'b0;
        stop = 1'b0;
        mid();
        check("both_state", 8'(state), 8'd0);
        check("both_clear_n", 8'(clear_n), 8'd0);
        nxt();
        mid();
        check("both_clear_n_after", 8'(clear_n), 8'd1);
        nxt();

        // IDLE: held stop gives a single clear cycle
        stop = 1'b1;
        nxt();
        mid();
        check("idle_stop_clear_n", 8'(clear_n), 8'd0);
        check("idle_stop_state", 8'(state), 8'd0);
        nxt();
        mid();
        check("idle_stop_held", 8'(clear_n), 8'd1);
        nxt();
        stop = 1'b0;

        // DONE exited by door open
        start = 1'b1;
        nxt();
        start = 1'b0;
        zero_all = 1'b1;
        nxt();
        door_closed = 1'b0;
        mid();
        check("done2_beep", 8'(beep), 8'd1);
        check("done2_lamp", 8'(lamp), 8'd1);
        nxt();
        door_closed = 1'b1;
        mid();
        check("done_door_state", 8'(state), 8'd0);
        check("done_door_beep", 8'(beep), 8'd0);
        check("done_door_clear_n", 8'(clear_n), 8'd1);
        nxt();

        // clr during DONE drops beep
        zero_all = 1'b0;
        start = 1'b1;
        nxt();
        start = 1'b0;
        zero_all = 1'b1;
        nxt();
        clr = 1'b1;
        mid();
        check("done3_state", 8'(state), 8'd3);
        nxt();
        clr = 1'b0;
        zero_all = 1'b0;
        mid();
        check("clr_done_beep", 8'(beep), 8'd0);
        check("clr_done_state", 8'(state), 8'd0);
        check("clr_done_clear_n", 8'(clear_n), 8'd0);
        nxt();

        // start held through clr deassertion -> exactly one press
        clr = 1'b1;
        start = 1'b1;
        nxt();
        clr = 1'b0;
        nxt();
        mid();
        check("held_start_cook", 8'(state), 8'd1);
        check("held_start_mag", 8'(mag_on), 8'd1);
        nxt();

        // clr in COOK with door open and stop press
        clr = 1'b1;
        door_closed = 1'b0;
        stop = 1'b1;
        nxt();
        mid();
        check("clr_cook_state", 8'(state), 8'd0);
        check("clr_cook_clear_n", 8'(clear_n), 8'd0);
        check("clr_cook_mag", 8'(mag_on), 8'd0);
        check("clr_cook_lamp", 8'(lamp), 8'd1);
        nxt();
        clr = 1'b0;
        door_closed = 1'b1;
        stop = 1'b0;
        start = 1'b0;
        nxt();
        mid();
        check("clr_cook_release_clear_n", 8'(clear_n), 8'd1);
        check("clr_cook_release_state", 8'(state), 8'd0);

        // final report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
